// File: rtl/dlx_mem_pkg.sv
// Shared types and defaults for the DLX memory arbiter.
package dlx_mem_pkg;
   localparam int WORD_W           = 32;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int MAX_WAIT_DEF     = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GNT_IF = 2'd1,
      ST_GNT_DM = 2'd2
   } arb_state_e;
endpackage

// File: rtl/dlx_arb_timer.sv
// Memory wait counter: cleared on grant, counts stalled cycles, saturates at MAX_WAIT.
module dlx_arb_timer #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   assign tc = (wait_cnt_q == CNT_W'(MAX_WAIT));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clr)
         wait_cnt_d = '0;
      else if (en && !tc)
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         wait_cnt_q <= '0;
      else
         wait_cnt_q <= wait_cnt_d;
   end
endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// state | meaning: IDLE no access / GNT_IF fetch owns port / GNT_DM data access owns port
module dlx_mem_arbiter
   import dlx_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int MAX_WAIT     = MAX_WAIT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [WORD_W-1:0] if_addr,
   output logic [WORD_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [WORD_W-1:0] dm_addr,
   input  logic [WORD_W-1:0] dm_wdata,
   output logic [WORD_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              timeout_err
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_e        state_q, state_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
   logic [WORD_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              terr_q, terr_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              grant;
   logic              wait_tc;

   dlx_arb_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clock (clock),
      .reset (reset),
      .clr   (grant),
      .en    ((state_q != ST_IDLE) && !mem_ready),
      .tc    (wait_tc)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      terr_d     = terr_q;
      starve_d   = starve_q;
      grant      = 1'b0;
      case (state_q)
         // The ack cycle is the separating idle cycle; requests still show there.
         ST_IDLE: begin
            if (!if_ack_q && !dm_ack_q) begin
               if (dm_req && !(if_req && starve_q == STARVE_MAX)) begin
                  state_d = ST_GNT_DM;
                  grant   = 1'b1;
                  addr_d  = dm_addr;
                  wdata_d = dm_wdata;
                  we_d    = dm_we;
                  if (!if_req)
                     starve_d = '0;
                  else if (starve_q != STARVE_MAX)
                     starve_d = starve_q + 1'b1;
               end else if (if_req) begin
                  state_d  = ST_GNT_IF;
                  grant    = 1'b1;
                  addr_d   = if_addr;
                  we_d     = 1'b0;
                  starve_d = '0;
               end
            end
         end
         ST_GNT_IF: begin
            if (mem_ready || wait_tc) begin
               state_d    = ST_IDLE;
               if_ack_d   = 1'b1;
               if_rdata_d = mem_ready ? mem_rdata : '0;
               terr_d     = terr_q | ~mem_ready;
            end
         end
         ST_GNT_DM: begin
            if (mem_ready || wait_tc) begin
               state_d  = ST_IDLE;
               dm_ack_d = 1'b1;
               if (!we_q)
                  dm_rdata_d = mem_ready ? mem_rdata : '0;
               terr_d   = terr_q | ~mem_ready;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         terr_q     <= 1'b0;
         starve_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         terr_q     <= terr_d;
         starve_q   <= starve_d;
      end
   end

   assign mem_en      = (state_q != ST_IDLE);
   assign mem_we      = (state_q == ST_GNT_DM) && we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign if_ack      = if_ack_q;
   assign dm_ack      = dm_ack_q;
   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign timeout_err = terr_q;
   assign stall_if    = if_req & ~if_ack_q;
   assign stall_mem   = dm_req & ~dm_ack_q;
endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Bench for dlx_mem_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_dlx_mem_arbiter;
   localparam int LIM = 4;
   localparam int MW  = 15;

   logic        clock;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        timeout_err;

   int n_chk  = 0;
   int n_pass = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   dlx_mem_arbiter #(.STARVE_LIMIT(LIM), .MAX_WAIT(MW)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      idle_inputs();
      tick(); tick();
      reset = 1'b0;
   endtask

   // Completes one load of d from a; starts and ends in a non-ack idle cycle.
   task automatic do_load(input logic [31:0] a, input logic [31:0] d);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = a;
      tick();
      mem_ready = 1'b1; mem_rdata = d;
      tick();
      n_chk++; if (dm_ack !== 1'b1) $display("FAIL preload_ack: got %0b want 1", dm_ack); else n_pass++;
      dm_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      if_req = 1'b1; dm_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick(); tick();
      n_chk++; if ({mem_en, mem_we, if_ack, dm_ack, timeout_err} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {mem_en, mem_we, if_ack, dm_ack, timeout_err}); else n_pass++;
      n_chk++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
      n_chk++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
      n_chk++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata: got %h want 0", if_rdata); else n_pass++;
      n_chk++; if (dm_rdata !== 32'h0) $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); else n_pass++;
      idle_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fetch;
      apply_reset();
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      n_chk++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_c0: got %0b want 1", stall_if); else n_pass++;
      tick();
      n_chk++; if ({mem_en, mem_we} !== 2'b10) $display("FAIL fetch_en_c1: got %b want 10", {mem_en, mem_we}); else n_pass++;
      n_chk++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr_c1: got %h want 100", mem_addr); else n_pass++;
      n_chk++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_c1: got %0b want 1", stall_if); else n_pass++;
      mem_ready = 1'b1; mem_rdata = 32'h2001_0005;
      tick();
      n_chk++; if (if_ack !== 1'b1) $display("FAIL fetch_ack_c2: got %0b want 1", if_ack); else n_pass++;
      n_chk++; if (if_rdata !== 32'h2001_0005) $display("FAIL fetch_rdata: got %h want 20010005", if_rdata); else n_pass++;
      n_chk++; if ({stall_if, mem_en} !== 2'b00) $display("FAIL fetch_stall_en_c2: got %b want 00", {stall_if, mem_en}); else n_pass++;
      if_req = 1'b0; mem_ready = 1'b0;
      tick();
      n_chk++; if (if_ack !== 1'b0) $display("FAIL fetch_ack_pulse: got %0b want 0", if_ack); else n_pass++;
   endtask

   task automatic test_simultaneous;
      apply_reset();
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      tick();
      n_chk++; if (mem_addr !== 32'h40) $display("FAIL sim_first_addr: got %h want 40", mem_addr); else n_pass++;
      n_chk++; if ({mem_en, mem_we} !== 2'b10) $display("FAIL sim_first_en: got %b want 10", {mem_en, mem_we}); else n_pass++;
      mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      n_chk++; if ({dm_ack, if_ack} !== 2'b10) $display("FAIL sim_dm_ack: got %b want 10", {dm_ack, if_ack}); else n_pass++;
      n_chk++; if (dm_rdata !== 32'h1111_2222) $display("FAIL sim_dm_rdata: got %h want 11112222", dm_rdata); else n_pass++;
      dm_req = 1'b0; mem_ready = 1'b0;
      tick();
      n_chk++; if (mem_en !== 1'b0) $display("FAIL sim_gap_idle: got %0b want 0", mem_en); else n_pass++;
      tick();
      n_chk++; if ({mem_en, mem_addr} !== {1'b1, 32'h100}) $display("FAIL sim_second_addr: got %0b/%h want 1/100", mem_en, mem_addr); else n_pass++;
      mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
      tick();
      n_chk++; if ({dm_ack, if_ack} !== 2'b01) $display("FAIL sim_if_ack: got %b want 01", {dm_ack, if_ack}); else n_pass++;
      n_chk++; if (if_rdata !== 32'h3333_4444) $display("FAIL sim_if_rdata: got %h want 33334444", if_rdata); else n_pass++;
      if_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      apply_reset();
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h0;
      mem_ready = 1'b1; mem_rdata = 32'h77;
      for (int g = 0; g < 5; g++) begin
         int w;
         logic exp_we;
         logic [31:0] exp_addr;
         w = 0;
         while (mem_en !== 1'b1 && w < 8) begin tick(); w++; end
         exp_we   = (g < 4);
         exp_addr = (g < 4) ? 32'h200 + 32'(4 * g) : 32'h100;
         n_chk++; if (mem_en !== 1'b1) $display("FAIL starve_grant%0d: got %0b want 1", g, mem_en); else n_pass++;
         n_chk++; if (mem_we !== exp_we) $display("FAIL starve_we%0d: got %0b want %0b", g, mem_we, exp_we); else n_pass++;
         n_chk++; if (mem_addr !== exp_addr) $display("FAIL starve_addr%0d: got %h want %h", g, mem_addr, exp_addr); else n_pass++;
         tick();
         n_chk++; if ({dm_ack, if_ack} !== {exp_we, ~exp_we}) $display("FAIL starve_ack%0d: got %b want %b", g, {dm_ack, if_ack}, {exp_we, ~exp_we}); else n_pass++;
         dm_addr = 32'h200 + 32'(4 * (g + 1)); dm_wdata = 32'(g + 1);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout;
      int k;
      int en_drop;
      apply_reset();
      do_load(32'h44, 32'hCAFE_0001);
      n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_pre: got %0b want 0", timeout_err); else n_pass++;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
      mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      tick();
      k = 1; en_drop = 0;
      while (dm_ack !== 1'b1 && k < 40) begin
         if (mem_en !== 1'b1) en_drop++;
         tick(); k++;
      end
      n_chk++; if (k != 17) $display("FAIL tmo_latency: got ack at cycle %0d want 17", k); else n_pass++;
      n_chk++; if (en_drop != 0) $display("FAIL tmo_en_held: got %0d idle cycles want 0", en_drop); else n_pass++;
      n_chk++; if (dm_rdata !== 32'h0) $display("FAIL tmo_rdata: got %h want 0", dm_rdata); else n_pass++;
      n_chk++; if ({timeout_err, mem_en} !== 2'b10) $display("FAIL tmo_flag: got %b want 10", {timeout_err, mem_en}); else n_pass++;
      dm_req = 1'b0;
      tick(); tick();
      do_load(32'h50, 32'h0000_0001);
      n_chk++; if (dm_rdata !== 32'h1) $display("FAIL tmo_recover_rdata: got %h want 1", dm_rdata); else n_pass++;
      n_chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %0b want 1", timeout_err); else n_pass++;
      apply_reset();
      n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_cleared: got %0b want 0", timeout_err); else n_pass++;
   endtask

   task automatic test_reset_mid_access;
      apply_reset();
      if_req = 1'b1; if_addr = 32'h300;
      tick();
      n_chk++; if (mem_en !== 1'b1) $display("FAIL rmid_granted: got %0b want 1", mem_en); else n_pass++;
      mem_ready = 1'b1; mem_rdata = 32'hABCD_0123; reset = 1'b1;
      tick();
      n_chk++; if ({if_ack, mem_en} !== 2'b00) $display("FAIL rmid_no_ack: got %b want 00", {if_ack, mem_en}); else n_pass++;
      n_chk++; if ({mem_addr, if_rdata} !== 64'h0) $display("FAIL rmid_regs: got %h/%h want 0/0", mem_addr, if_rdata); else n_pass++;
      reset = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
      tick();
      n_chk++; if ({if_ack, mem_en} !== 2'b00) $display("FAIL rmid_after: got %b want 00", {if_ack, mem_en}); else n_pass++;
   endtask

   task automatic test_store;
      apply_reset();
      do_load(32'h10, 32'h5A5A_5A5A);
      dm_req = 1'b1; dm_we = 1'b1; dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h8;
      tick();
      for (int c = 1; c <= 3; c++) begin
         n_chk++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h8, 32'hDEAD_BEEF})
            $display("FAIL store_hold_c%0d: got %b%b/%h/%h want 11/8/deadbeef", c, mem_en, mem_we, mem_addr, mem_wdata); else n_pass++;
         if (c == 2) begin dm_addr = 32'hFFF0; dm_wdata = 32'h0; dm_we = 1'b0; end
         tick();
      end
      n_chk++; if (dm_ack !== 1'b0) $display("FAIL store_early_ack: got %0b want 0", dm_ack); else n_pass++;
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      n_chk++; if (dm_ack !== 1'b1) $display("FAIL store_ack_c5: got %0b want 1", dm_ack); else n_pass++;
      n_chk++; if (dm_rdata !== 32'h5A5A_5A5A) $display("FAIL store_rdata_hold: got %h want 5a5a5a5a", dm_rdata); else n_pass++;
      idle_inputs();
      tick();
   endtask

   // Transaction model: grant choice from the starvation rule, ack time from the chosen memory latency.
   task automatic test_random;
      bit          m_busy, m_dm, m_we, m_tmo, m_terr, if_pend, dm_pend;
      bit          exp_en, exp_if_ack, exp_dm_ack;
      int          m_start, m_end, m_lat, ack_cyc, starve;
      logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
      apply_reset();
      m_busy = 0; m_dm = 0; m_we = 0; m_tmo = 0; m_terr = 0; if_pend = 0; dm_pend = 0;
      m_start = 0; m_end = 0; m_lat = 0; ack_cyc = -5; starve = 0;
      m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
      for (int n = 0; n < 700; n++) begin
         exp_en     = m_busy && n >= m_start && n < m_end;
         exp_if_ack = m_busy && n == m_end && !m_dm;
         exp_dm_ack = m_busy && n == m_end && m_dm;
         if (m_busy && n == m_end) begin
            if (!m_dm) m_if_rd = m_tmo ? 32'h0 : mem_fn(m_addr);
            else if (!m_we) m_dm_rd = m_tmo ? 32'h0 : mem_fn(m_addr);
            if (m_tmo) m_terr = 1;
            m_busy = 0; ack_cyc = n;
         end
         n_chk++; if (mem_en !== exp_en) $display("FAIL rnd_mem_en@%0d: got %0b want %0b", n, mem_en, exp_en); else n_pass++;
         n_chk++; if ({if_ack, dm_ack} !== {exp_if_ack, exp_dm_ack})
            $display("FAIL rnd_ack@%0d: got %b want %b", n, {if_ack, dm_ack}, {exp_if_ack, exp_dm_ack}); else n_pass++;
         n_chk++; if ({if_rdata, dm_rdata} !== {m_if_rd, m_dm_rd})
            $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", n, if_rdata, dm_rdata, m_if_rd, m_dm_rd); else n_pass++;
         n_chk++; if (timeout_err !== m_terr) $display("FAIL rnd_terr@%0d: got %0b want %0b", n, timeout_err, m_terr); else n_pass++;
         n_chk++; if ({stall_if, stall_mem} !== {if_req & ~exp_if_ack, dm_req & ~exp_dm_ack})
            $display("FAIL rnd_stall@%0d: got %b want %b", n, {stall_if, stall_mem}, {if_req & ~exp_if_ack, dm_req & ~exp_dm_ack}); else n_pass++;
         if (exp_en) begin
            n_chk++; if ({mem_addr, mem_we} !== {m_addr, m_dm & m_we})
               $display("FAIL rnd_port@%0d: got %h/%0b want %h/%0b", n, mem_addr, mem_we, m_addr, m_dm & m_we); else n_pass++;
            if (m_dm && m_we) begin
               n_chk++; if (mem_wdata !== m_wdata) $display("FAIL rnd_wdata@%0d: got %h want %h", n, mem_wdata, m_wdata); else n_pass++;
            end
         end
         if (exp_if_ack) if_pend = 0;
         if (exp_dm_ack) dm_pend = 0;
         if (!if_pend && $urandom_range(0, 1) == 0) begin
            if_pend = 1; if_addr = {$urandom_range(0, 65535), 2'b00};
         end
         if (!dm_pend && $urandom_range(0, 3) != 0) begin
            dm_pend = 1; dm_we = 1'($urandom_range(0, 1));
            dm_addr = {$urandom_range(0, 65535), 2'b00}; dm_wdata = $urandom;
         end
         if_req = if_pend; dm_req = dm_pend;
         if (!m_busy && n != ack_cyc && (if_pend || dm_pend)) begin
            m_dm = dm_pend && !(if_pend && starve == LIM);
            if (m_dm) begin
               starve  = if_pend ? ((starve < LIM) ? starve + 1 : LIM) : 0;
               m_addr  = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            end else begin
               starve = 0; m_addr = if_addr; m_we = 0;
            end
            m_lat   = ($urandom_range(0, 11) == 0) ? 20 : $urandom_range(0, 3);
            m_tmo   = (m_lat > MW);
            m_start = n + 1;
            m_end   = n + 1 + (m_tmo ? MW : m_lat) + 1;
            m_busy  = 1;
         end
         if (exp_en) begin
            mem_ready = ((n - m_start) == m_lat);
            mem_rdata = mem_fn(m_addr);
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_fetch();
      test_simultaneous();
      test_starvation();
      test_timeout();
      test_reset_mid_access();
      test_store();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
